// File: rtl/bp_piton_l15_return_decoder.sv
// L1.5 return-message decoder for a BlackParrot L1 cache: turns fills, uncached/atomic
// returns, store acks and evictions into data-mem/tag-mem writes, data pulses and credit returns.

module bp_piton_l15_return_decoder #(
    parameter int paddr_width_p = 40,
    parameter int sets_p        = 128,
    parameter int assoc_p       = 4,
    parameter int block_width_p = 256,
    localparam int offset_w = $clog2(block_width_p / 8),
    localparam int index_w  = $clog2(sets_p),
    localparam int way_w    = $clog2(assoc_p),
    localparam int tag_w    = paddr_width_p - index_w - offset_w
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     l15_val_i,
    input  logic [3:0]               l15_returntype_i,
    input  logic                     l15_noncacheable_i,
    input  logic [255:0]             l15_data_i,
    input  logic [11:0]              l15_inval_addr_i,
    input  logic                     l15_inval_all_way_i,
    input  logic [1:0]               l15_inval_way_i,
    output logic                     l15_ack_o,

    input  logic                     pend_v_i,
    input  logic [paddr_width_p-1:0] pend_addr_i,
    input  logic [way_w-1:0]         pend_way_i,

    output logic                     data_mem_v_o,
    input  logic                     data_mem_ready_and_i,
    output logic [index_w-1:0]       data_mem_index_o,
    output logic [way_w-1:0]         data_mem_way_o,
    output logic [block_width_p-1:0] data_mem_data_o,

    output logic                     tag_mem_v_o,
    input  logic                     tag_mem_ready_and_i,
    output logic [1:0]               tag_mem_opcode_o,
    output logic [index_w-1:0]       tag_mem_index_o,
    output logic [way_w-1:0]         tag_mem_way_o,
    output logic [tag_w-1:0]         tag_mem_tag_o,

    output logic                     uc_data_v_o,
    output logic [63:0]              uc_data_o,
    output logic                     st_ack_o,
    output logic                     credit_return_o
);

    if ((block_width_p != 128) && (block_width_p != 256)) begin : g_bad_block_width
        $error("block_width_p must be 128 or 256");
    end
    if (offset_w + index_w > 16) begin : g_bad_geometry
        $error("offset_w + index_w must not exceed 16");
    end
    if (assoc_p < 2) begin : g_bad_assoc
        $error("assoc_p must be at least 2");
    end

    localparam logic [3:0] RT_LOAD   = 4'b0000;
    localparam logic [3:0] RT_IFILL  = 4'b0001;
    localparam logic [3:0] RT_EVICT  = 4'b0011;
    localparam logic [3:0] RT_ST_ACK = 4'b0100;
    localparam logic [3:0] RT_ATOMIC = 4'b1000;

    localparam logic [1:0] OP_SET_VALID = 2'd0;
    localparam logic [1:0] OP_INV_WAY   = 2'd1;
    localparam logic [1:0] OP_INV_ALL   = 2'd2;

    typedef enum logic [2:0] {e_idle, e_data, e_tag, e_uc, e_done} state_e;

    state_e                   state_q, state_d;
    logic [block_width_p-1:0] data_q, data_d;
    logic [63:0]              uc_data_q, uc_data_d;
    logic [index_w-1:0]       index_q, index_d;
    logic [way_w-1:0]         way_q, way_d;
    logic [tag_w-1:0]         tag_q, tag_d;
    logic [1:0]               opcode_q, opcode_d;
    logic                     evict_q, evict_d;
    logic                     st_q, st_d;

    logic                     accept_s;
    logic                     is_fill_s, is_uc_s, is_st_s, is_evict_s;
    logic [index_w-1:0]       pend_index_s, inval_index_s;
    logic [tag_w-1:0]         pend_tag_s;
    logic [15:0]              inval_paddr_s;
    logic [way_w-1:0]         inval_way_s;
    logic [63:0]              uc_word_s;
    logic                     unused_s;

    assign accept_s   = (state_q == e_idle) & l15_val_i & ~reset_i;
    assign is_fill_s  = ((l15_returntype_i == RT_LOAD) & ~l15_noncacheable_i)
                      | (l15_returntype_i == RT_IFILL);
    assign is_uc_s    = ((l15_returntype_i == RT_LOAD) & l15_noncacheable_i)
                      | (l15_returntype_i == RT_ATOMIC);
    assign is_st_s    = (l15_returntype_i == RT_ST_ACK);
    assign is_evict_s = (l15_returntype_i == RT_EVICT);

    assign pend_index_s  = pend_addr_i[offset_w +: index_w];
    assign pend_tag_s    = pend_addr_i[paddr_width_p-1 -: tag_w];
    // The invalidate field carries paddr[15:4]; rebuild a 16-bit address to slice the index.
    assign inval_paddr_s = {l15_inval_addr_i, 4'b0000};
    assign inval_index_s = inval_paddr_s[offset_w +: index_w];
    assign inval_way_s   = way_w'(l15_inval_way_i);
    assign uc_word_s     = pend_addr_i[3] ? l15_data_i[127:64] : l15_data_i[63:0];

    assign unused_s = ^{l15_data_i, pend_addr_i, l15_inval_addr_i, l15_inval_way_i};

    // State register and message capture
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            data_q    <= '0;
            uc_data_q <= 64'd0;
            index_q   <= '0;
            way_q     <= '0;
            tag_q     <= '0;
            opcode_q  <= 2'd0;
            evict_q   <= 1'b0;
            st_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            uc_data_q <= uc_data_d;
            index_q   <= index_d;
            way_q     <= way_d;
            tag_q     <= tag_d;
            opcode_q  <= opcode_d;
            evict_q   <= evict_d;
            st_q      <= st_d;
        end
    end

    // Next-state and capture selection
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        uc_data_d = uc_data_q;
        index_d   = index_q;
        way_d     = way_q;
        tag_d     = tag_q;
        opcode_d  = opcode_q;
        evict_d   = evict_q;
        st_d      = st_q;
        case (state_q)
            e_idle: begin
                if (accept_s) begin
                    evict_d = 1'b0;
                    st_d    = 1'b0;
                    if (is_fill_s && pend_v_i) begin
                        data_d   = l15_data_i[block_width_p-1:0];
                        index_d  = pend_index_s;
                        way_d    = pend_way_i;
                        tag_d    = pend_tag_s;
                        opcode_d = OP_SET_VALID;
                        state_d  = e_data;
                    end else if (is_fill_s) begin
                        // Fill with no miss registered: skip the writes, still give the credit back.
                        state_d = e_done;
                    end else if (is_uc_s) begin
                        uc_data_d = uc_word_s;
                        state_d   = e_uc;
                    end else if (is_st_s) begin
                        st_d    = 1'b1;
                        state_d = e_done;
                    end else if (is_evict_s) begin
                        index_d  = inval_index_s;
                        way_d    = inval_way_s;
                        tag_d    = '0;
                        opcode_d = l15_inval_all_way_i ? OP_INV_ALL : OP_INV_WAY;
                        evict_d  = 1'b1;
                        state_d  = e_tag;
                    end else begin
                        state_d = e_idle;
                    end
                end else begin
                    state_d = e_idle;
                end
            end
            e_data: begin
                if (data_mem_ready_and_i) begin
                    state_d = e_tag;
                end else begin
                    state_d = e_data;
                end
            end
            e_tag: begin
                if (tag_mem_ready_and_i) begin
                    state_d = evict_q ? e_idle : e_done;
                end else begin
                    state_d = e_tag;
                end
            end
            e_uc:    state_d = e_idle;
            e_done:  state_d = e_idle;
            default: state_d = e_idle;
        endcase
    end

    // Output decode; payloads are driven only while their valid is up
    always_comb begin
        l15_ack_o        = accept_s;
        data_mem_v_o     = 1'b0;
        data_mem_index_o = '0;
        data_mem_way_o   = '0;
        data_mem_data_o  = '0;
        tag_mem_v_o      = 1'b0;
        tag_mem_opcode_o = 2'd0;
        tag_mem_index_o  = '0;
        tag_mem_way_o    = '0;
        tag_mem_tag_o    = '0;
        uc_data_v_o      = 1'b0;
        uc_data_o        = 64'd0;
        st_ack_o         = 1'b0;
        credit_return_o  = 1'b0;
        if (reset_i) begin
            l15_ack_o = 1'b0;
        end else begin
            case (state_q)
                e_data: begin
                    data_mem_v_o     = 1'b1;
                    data_mem_index_o = index_q;
                    data_mem_way_o   = way_q;
                    data_mem_data_o  = data_q;
                end
                e_tag: begin
                    tag_mem_v_o      = 1'b1;
                    tag_mem_opcode_o = opcode_q;
                    tag_mem_index_o  = index_q;
                    tag_mem_way_o    = way_q;
                    tag_mem_tag_o    = tag_q;
                end
                e_uc: begin
                    uc_data_v_o     = 1'b1;
                    uc_data_o       = uc_data_q;
                    credit_return_o = 1'b1;
                end
                e_done: begin
                    st_ack_o        = st_q;
                    credit_return_o = 1'b1;
                end
                default: begin
                    credit_return_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_piton_l15_return_decoder.sv
// Bench for the D$ (128-bit block) decoder: a transaction-level model turns each accepted
// message into a list of write/pulse steps and is compared against the DUT every cycle.

module tb_bp_piton_l15_return_decoder;

    localparam int PAW = 40;
    localparam int BW  = 128;
    localparam int IW  = 7;
    localparam int WW  = 2;
    localparam int TW  = 29;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           l15_val_i;
    logic [3:0]     l15_returntype_i;
    logic           l15_noncacheable_i;
    logic [255:0]   l15_data_i;
    logic [11:0]    l15_inval_addr_i;
    logic           l15_inval_all_way_i;
    logic [1:0]     l15_inval_way_i;
    logic           l15_ack_o;
    logic           pend_v_i;
    logic [PAW-1:0] pend_addr_i;
    logic [WW-1:0]  pend_way_i;
    logic           data_mem_v_o;
    logic           data_mem_ready_and_i;
    logic [IW-1:0]  data_mem_index_o;
    logic [WW-1:0]  data_mem_way_o;
    logic [BW-1:0]  data_mem_data_o;
    logic           tag_mem_v_o;
    logic           tag_mem_ready_and_i;
    logic [1:0]     tag_mem_opcode_o;
    logic [IW-1:0]  tag_mem_index_o;
    logic [WW-1:0]  tag_mem_way_o;
    logic [TW-1:0]  tag_mem_tag_o;
    logic           uc_data_v_o;
    logic [63:0]    uc_data_o;
    logic           st_ack_o;
    logic           credit_return_o;

    bp_piton_l15_return_decoder #(
        .paddr_width_p(PAW), .sets_p(128), .assoc_p(4), .block_width_p(BW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .l15_val_i(l15_val_i), .l15_returntype_i(l15_returntype_i),
        .l15_noncacheable_i(l15_noncacheable_i), .l15_data_i(l15_data_i),
        .l15_inval_addr_i(l15_inval_addr_i), .l15_inval_all_way_i(l15_inval_all_way_i),
        .l15_inval_way_i(l15_inval_way_i), .l15_ack_o(l15_ack_o),
        .pend_v_i(pend_v_i), .pend_addr_i(pend_addr_i), .pend_way_i(pend_way_i),
        .data_mem_v_o(data_mem_v_o), .data_mem_ready_and_i(data_mem_ready_and_i),
        .data_mem_index_o(data_mem_index_o), .data_mem_way_o(data_mem_way_o),
        .data_mem_data_o(data_mem_data_o),
        .tag_mem_v_o(tag_mem_v_o), .tag_mem_ready_and_i(tag_mem_ready_and_i),
        .tag_mem_opcode_o(tag_mem_opcode_o), .tag_mem_index_o(tag_mem_index_o),
        .tag_mem_way_o(tag_mem_way_o), .tag_mem_tag_o(tag_mem_tag_o),
        .uc_data_v_o(uc_data_v_o), .uc_data_o(uc_data_o),
        .st_ack_o(st_ack_o), .credit_return_o(credit_return_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit run_chk = 1'b0;

    initial begin : cycle_counter
        forever begin
            @(posedge clk_i);
            cycle = cycle + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    localparam int K_DATA  = 0;
    localparam int K_TAG   = 1;
    localparam int K_PULSE = 2;

    typedef struct {
        int            kind;
        logic [IW-1:0] idx;
        logic [WW-1:0] way;
        logic [BW-1:0] data;
        logic [1:0]    op;
        logic [TW-1:0] tag;
        logic          uc;
        logic [63:0]   word;
        logic          st;
    } step_t;

    step_t steps[$];

    task automatic push_step(input int kind, input logic [IW-1:0] idx, input logic [WW-1:0] way,
                             input logic [BW-1:0] data, input logic [1:0] op, input logic [TW-1:0] tag,
                             input logic uc, input logic [63:0] word, input logic st);
        step_t s;
        s.kind = kind; s.idx = idx; s.way = way; s.data = data; s.op = op;
        s.tag = tag; s.uc = uc; s.word = word; s.st = st;
        steps.push_back(s);
    endtask

    // Expand the message currently on the inputs into the steps it must produce.
    task automatic expand_message();
        logic fill, ucm;
        logic [63:0] w;
        fill = ((l15_returntype_i == 4'd0) && !l15_noncacheable_i) || (l15_returntype_i == 4'd1);
        ucm  = ((l15_returntype_i == 4'd0) && l15_noncacheable_i) || (l15_returntype_i == 4'd8);
        if (fill && pend_v_i) begin
            push_step(K_DATA, IW'((pend_addr_i / 16) % 128), pend_way_i, l15_data_i[BW-1:0],
                      2'd0, '0, 1'b0, 64'd0, 1'b0);
            push_step(K_TAG, IW'((pend_addr_i / 16) % 128), pend_way_i, '0,
                      2'd0, TW'(pend_addr_i / 2048), 1'b0, 64'd0, 1'b0);
            push_step(K_PULSE, '0, '0, '0, 2'd0, '0, 1'b0, 64'd0, 1'b0);
        end else if (fill) begin
            push_step(K_PULSE, '0, '0, '0, 2'd0, '0, 1'b0, 64'd0, 1'b0);
        end else if (ucm) begin
            w = (((pend_addr_i / 8) % 2) == 1) ? l15_data_i[127:64] : l15_data_i[63:0];
            push_step(K_PULSE, '0, '0, '0, 2'd0, '0, 1'b1, w, 1'b0);
        end else if (l15_returntype_i == 4'd4) begin
            push_step(K_PULSE, '0, '0, '0, 2'd0, '0, 1'b0, 64'd0, 1'b1);
        end else if (l15_returntype_i == 4'd3) begin
            // 16-byte blocks: the index is simply the low 7 bits of the paddr[15:4] field.
            push_step(K_TAG, IW'(l15_inval_addr_i % 128), WW'(l15_inval_way_i), '0,
                      l15_inval_all_way_i ? 2'd2 : 2'd1, '0, 1'b0, 64'd0, 1'b0);
        end
    endtask

    initial begin : compare
        step_t h;
        logic e_ack, e_dv, e_tv, e_uv, e_st, e_cr;
        logic [IW-1:0] e_di, e_ti;
        logic [WW-1:0] e_dw, e_tw;
        logic [BW-1:0] e_dd;
        logic [1:0]    e_op;
        logic [TW-1:0] e_tag;
        logic [63:0]   e_ud;
        forever begin
            @(negedge clk_i);
            if (run_chk) begin
                e_ack = 1'b0; e_dv = 1'b0; e_tv = 1'b0; e_uv = 1'b0; e_st = 1'b0; e_cr = 1'b0;
                e_di = '0; e_ti = '0; e_dw = '0; e_tw = '0; e_dd = '0; e_op = 2'd0;
                e_tag = '0; e_ud = 64'd0;
                if (reset_i) begin
                    steps.delete();
                end else if (steps.size() == 0) begin
                    e_ack = l15_val_i;
                    if (l15_val_i) expand_message();
                end else begin
                    h = steps[0];
                    if (h.kind == K_DATA) begin
                        e_dv = 1'b1; e_di = h.idx; e_dw = h.way; e_dd = h.data;
                        if (data_mem_ready_and_i) void'(steps.pop_front());
                    end else if (h.kind == K_TAG) begin
                        e_tv = 1'b1; e_ti = h.idx; e_tw = h.way; e_op = h.op; e_tag = h.tag;
                        if (tag_mem_ready_and_i) void'(steps.pop_front());
                    end else begin
                        e_cr = 1'b1; e_uv = h.uc; e_ud = h.word; e_st = h.st;
                        void'(steps.pop_front());
                    end
                end
                chk("ack",       256'(l15_ack_o),        256'(e_ack));
                chk("dmem_v",    256'(data_mem_v_o),     256'(e_dv));
                chk("dmem_idx",  256'(data_mem_index_o), 256'(e_di));
                chk("dmem_way",  256'(data_mem_way_o),   256'(e_dw));
                chk("dmem_data", 256'(data_mem_data_o),  256'(e_dd));
                chk("tmem_v",    256'(tag_mem_v_o),      256'(e_tv));
                chk("tmem_op",   256'(tag_mem_opcode_o), 256'(e_op));
                chk("tmem_idx",  256'(tag_mem_index_o),  256'(e_ti));
                chk("tmem_way",  256'(tag_mem_way_o),    256'(e_tw));
                chk("tmem_tag",  256'(tag_mem_tag_o),    256'(e_tag));
                chk("uc_v",      256'(uc_data_v_o),      256'(e_uv));
                chk("uc_data",   256'(uc_data_o),        256'(e_ud));
                chk("st_ack",    256'(st_ack_o),         256'(e_st));
                chk("credit",    256'(credit_return_o),  256'(e_cr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] rt, input logic nc, input logic [255:0] d,
                         input logic pv, input logic [PAW-1:0] pa, input logic [WW-1:0] pw,
                         input logic [11:0] ia, input logic aw, input logic [1:0] iw);
        l15_returntype_i = rt; l15_noncacheable_i = nc; l15_data_i = d;
        pend_v_i = pv; pend_addr_i = pa; pend_way_i = pw;
        l15_inval_addr_i = ia; l15_inval_all_way_i = aw; l15_inval_way_i = iw;
        l15_val_i = 1'b1;
    endtask

    // Wait (bounded) for the ack, then withdraw the message and scramble the capture inputs.
    task automatic wait_ack(output int at_cycle);
        bit got;
        got = 1'b0;
        at_cycle = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk_i);
            if (l15_ack_o) begin
                got = 1'b1;
                at_cycle = cycle;
            end
            @(posedge clk_i);
            #1;
        end
        if (!got) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ack_timeout @cycle %0d: got no ack expected ack within 64 cycles", cycle);
        end
        l15_val_i   = 1'b0;
        pend_addr_i = {$urandom, $urandom};
        pend_way_i  = WW'($urandom);
        for (int k = 0; k < 8; k++) l15_data_i[k*32 +: 32] = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    logic [255:0] d;
    int s0, a0, a1, a2;

    initial begin : stimulus
        reset_i = 1'b1; l15_val_i = 1'b0; l15_returntype_i = 4'd0; l15_noncacheable_i = 1'b0;
        l15_data_i = '0; l15_inval_addr_i = 12'd0; l15_inval_all_way_i = 1'b0;
        l15_inval_way_i = 2'd0; pend_v_i = 1'b0; pend_addr_i = '0; pend_way_i = '0;
        data_mem_ready_and_i = 1'b1; tag_mem_ready_and_i = 1'b1;
        @(posedge clk_i); #1;
        run_chk = 1'b1;
        idle(2);
        reset_i = 1'b0;
        idle(1);

        // D$ fill, ready tied high
        d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        s0 = cycle;
        drive(4'd0, 1'b0, d, 1'b1, 40'h00_8000_1230, 2'd1, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        chk("fill_ack_cycle", 256'(a0), 256'(s0));
        @(negedge clk_i);
        chk("fill_dmem_v",    256'(data_mem_v_o), 256'(1'b1));
        chk("fill_dmem_idx",  256'(data_mem_index_o), 256'(7'h23));
        chk("fill_dmem_way",  256'(data_mem_way_o), 256'(2'd1));
        chk("fill_dmem_data", 256'(data_mem_data_o),
            256'(128'h2222_2222_2222_2222_1111_1111_1111_1111));
        @(negedge clk_i);
        chk("fill_tmem_v",    256'(tag_mem_v_o), 256'(1'b1));
        chk("fill_tmem_tag",  256'(tag_mem_tag_o), 256'(29'h0100002));
        @(negedge clk_i);
        chk("fill_credit",    256'(credit_return_o), 256'(1'b1));
        idle(2);

        // Backpressure: data-mem stalls five cycles while a store ack is offered
        data_mem_ready_and_i = 1'b0;
        d = {64'h0, 64'h0, 64'hA5A5_0000_FFFF_1234, 64'h0F0F_F0F0_1357_2468};
        drive(4'd1, 1'b0, d, 1'b1, 40'h12_3456_7890, 2'd2, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        drive(4'd4, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_no_ack",  256'(l15_ack_o), 256'(1'b0));
            chk("bp_dmem_v",  256'(data_mem_v_o), 256'(1'b1));
            chk("bp_no_tag",  256'(tag_mem_v_o), 256'(1'b0));
            @(posedge clk_i); #1;
        end
        data_mem_ready_and_i = 1'b1;
        wait_ack(a1);
        idle(3);

        // Uncached load selecting data_1, then an atomic selecting data_0
        d = {128'h0, 64'h0000_0000_DEAD_BEEF, 64'hCAFE_F00D_0000_0001};
        drive(4'd0, 1'b1, d, 1'b1, 40'h00_0000_0008, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        @(negedge clk_i);
        chk("uc_pulse",  256'(uc_data_v_o), 256'(1'b1));
        chk("uc_word",   256'(uc_data_o), 256'(64'h0000_0000_DEAD_BEEF));
        chk("uc_credit", 256'(credit_return_o), 256'(1'b1));
        @(posedge clk_i); #1;
        drive(4'd8, 1'b0, d, 1'b1, 40'h00_0000_0010, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        idle(2);

        // Evict all ways at index 5 with a stalled tag-mem, then evict way 3
        tag_mem_ready_and_i = 1'b0;
        drive(4'd3, 1'b0, '0, 1'b0, '0, 2'd0, 12'h005, 1'b1, 2'd0);
        wait_ack(a0);
        @(negedge clk_i);
        chk("ev_all_op",  256'(tag_mem_opcode_o), 256'(2'd2));
        chk("ev_all_idx", 256'(tag_mem_index_o), 256'(7'd5));
        @(posedge clk_i); #1;
        tag_mem_ready_and_i = 1'b1;
        idle(1);
        drive(4'd3, 1'b0, '0, 1'b0, '0, 2'd0, 12'h0A7, 1'b0, 2'd3);
        wait_ack(a0);
        @(negedge clk_i);
        chk("ev_way_op",     256'(tag_mem_opcode_o), 256'(2'd1));
        chk("ev_way_way",    256'(tag_mem_way_o), 256'(2'd3));
        @(negedge clk_i);
        chk("ev_no_credit",  256'(credit_return_o), 256'(1'b0));
        idle(2);

        // Three store acks back to back
        drive(4'd4, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        drive(4'd4, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a1);
        drive(4'd4, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a2);
        chk("st_gap_1", 256'(a1 - a0), 256'(2));
        chk("st_gap_2", 256'(a2 - a1), 256'(2));
        idle(2);

        // Fill without a registered miss, then an unknown type immediately followed by a store ack
        drive(4'd0, 1'b0, d, 1'b0, 40'h00_0000_1000, 2'd1, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        @(negedge clk_i);
        chk("nopend_credit", 256'(credit_return_o), 256'(1'b1));
        chk("nopend_no_dmem", 256'(data_mem_v_o), 256'(1'b0));
        @(posedge clk_i); #1;
        drive(4'd2, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        drive(4'd4, 1'b0, '0, 1'b0, '0, 2'd0, 12'd0, 1'b0, 2'd0);
        wait_ack(a1);
        chk("unknown_then_next", 256'(a1 - a0), 256'(1));
        idle(3);

        // Reset while in the data-write phase
        data_mem_ready_and_i = 1'b0;
        drive(4'd0, 1'b0, d, 1'b1, 40'h00_0000_4560, 2'd3, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        @(negedge clk_i);
        chk("rst_pre_dmem_v", 256'(data_mem_v_o), 256'(1'b1));
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        data_mem_ready_and_i = 1'b1;
        @(negedge clk_i);
        chk("rst_dmem_v", 256'(data_mem_v_o), 256'(1'b0));
        chk("rst_credit", 256'(credit_return_o), 256'(1'b0));
        @(posedge clk_i); #1;
        s0 = cycle;
        drive(4'd0, 1'b0, d, 1'b1, 40'h00_0000_4560, 2'd3, 12'd0, 1'b0, 2'd0);
        wait_ack(a0);
        chk("rst_then_ack", 256'(a0), 256'(s0));
        @(negedge clk_i);
        chk("rst_then_idx", 256'(data_mem_index_o), 256'(7'h56));
        idle(5);

        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
